muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit with architectural HI/LO registers: the parametrised, sequential companion to the single-cycle ALU. It executes MIPS `mult`, `multu`, `div` and `divu` iteratively in n cycles using a shift-add multiplier and a restoring divider. It exposes a start/busy/done handshake to the pipeline and accepts `mthi`/`mtlo` writes. It sits in the execute stage beside the ALU; the pipeline stalls `mfhi`/`mflo` while `busy` is high.

---
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, n iterations plus one fix-up cycle.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes accepted
// RUN   | n iterations of shift-add or restoring divide
// FIX   | sign correction, HI/LO update, done pulse (also div-by-zero report)
module muldiv_unit #(
  parameter int n = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  input  logic         wr_hi_i,
  input  logic         wr_lo_i,
  input  logic [n-1:0] wdata_i,
  output logic [n-1:0] hi_o,
  output logic [n-1:0] lo_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         divz_o
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           is_div_q, is_div_d;
  logic           sa_q, sa_d;
  logic           sb_q, sb_d;
  logic           dz_q, dz_d;
  logic [n-1:0]   opnd_q, opnd_d;
  logic [2*n-1:0] acc_q, acc_d;
  logic [n-1:0]   hi_q, hi_d;
  logic [n-1:0]   lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           divz_q, divz_d;

  logic           op_signed;
  logic           op_div;
  logic [n-1:0]   a_mag;
  logic [n-1:0]   b_mag;
  logic [n:0]     mul_sum;
  logic [n:0]     div_trial;
  logic [2*n-1:0] prod_neg;
  logic [n-1:0]   quo;
  logic [n-1:0]   rem;

  assign op_signed = ~op_i[0];
  assign op_div    = op_i[1];
  assign a_mag     = (op_signed && a_i[n-1]) ? -a_i : a_i;
  assign b_mag     = (op_signed && b_i[n-1]) ? -b_i : b_i;

  // Upper half of acc is the partial product (mult) or remainder (div).
  assign mul_sum   = {1'b0, acc_q[2*n-1:n]} + {1'b0, opnd_q};
  assign div_trial = acc_q[2*n-1:n-1] - {1'b0, opnd_q};
  assign prod_neg  = -acc_q;
  assign quo       = acc_q[n-1:0];
  assign rem       = acc_q[2*n-1:n];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    divz_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_hi_i) hi_d = wdata_i;
        if (wr_lo_i) lo_d = wdata_i;
        if (start_i) begin
          is_div_d = op_div;
          sa_d     = op_signed & a_i[n-1];
          sb_d     = op_signed & b_i[n-1];
          cnt_d    = '0;
          if (op_div && (b_i == '0)) begin
            dz_d    = 1'b1;
            state_d = S_FIX;
          end else begin
            dz_d    = 1'b0;
            state_d = S_RUN;
            acc_d   = {{n{1'b0}}, (op_div ? a_mag : b_mag)};
            opnd_d  = op_div ? b_mag : a_mag;
          end
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          if (!div_trial[n]) acc_d = {div_trial[n-1:0], acc_q[n-2:0], 1'b1};
          else               acc_d = {acc_q[2*n-2:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {mul_sum, acc_q[n-1:1]};
          else          acc_d = {1'b0, acc_q[2*n-1:1]};
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (dz_q) begin
          divz_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = (sa_q ^ sb_q) ? -quo : quo;
          hi_d = sa_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : acc_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      divz_q   <= divz_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign divz_o = divz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, handshake/reset
// sequences and randomized operations against a plain-arithmetic model.
module tb_muldiv_unit;

  localparam int N = 32;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          start_i;
  logic [1:0]    op_i;
  logic [N-1:0]  a_i, b_i, wdata_i;
  logic          wr_hi_i, wr_lo_i;
  logic [N-1:0]  hi_o, lo_o;
  logic          busy_o, done_o, divz_o;

  always #5 clk_i = ~clk_i;

  muldiv_unit #(.n(N)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .wr_hi_i (wr_hi_i),
    .wr_lo_i (wr_lo_i),
    .wdata_i (wdata_i),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .divz_o  (divz_o)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // MIPS semantics from plain 64-bit arithmetic; writes apply before the op.
  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic whi, input logic wlo, input logic [31:0] wd,
                                 inout logic [31:0] h, inout logic [31:0] l, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    if (whi) h = wd;
    if (wlo) l = wd;
    dz = 1'b0;
    sa = op[0] ? longint'({32'd0, a}) : longint'($signed(a));
    sb = op[0] ? longint'({32'd0, b}) : longint'($signed(b));
    if (!op[1]) begin
      p = sa * sb;
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      l = q[31:0];
      h = r[31:0];
    end
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic whi, input logic wlo, input logic [31:0] wd,
                        input logic disturb,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz,
                        input string name);
    int k, bcnt, lat;
    logic hold_ok;
    logic [31:0] h0, l0;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    wr_hi_i = whi; wr_lo_i = wlo; wdata_i = wd;
    tick();
    start_i = 1'b0; wr_hi_i = 1'b0; wr_lo_i = 1'b0;
    h0 = hi_o; l0 = lo_o;
    k = 0; bcnt = 0; hold_ok = 1'b1;
    while (!done_o && k < 3 * N) begin
      if (busy_o) bcnt++;
      if (hi_o !== h0 || lo_o !== l0) hold_ok = 1'b0;
      if (disturb && k == 5) begin
        start_i = 1'b1; op_i = op ^ 2'b10; a_i = ~a; b_i = b + 32'd1;
        wr_hi_i = 1'b1; wr_lo_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
      end else begin
        start_i = 1'b0; wr_hi_i = 1'b0; wr_lo_i = 1'b0;
      end
      tick();
      k++;
    end
    start_i = 1'b0; wr_hi_i = 1'b0; wr_lo_i = 1'b0;
    lat = exp_dz ? 1 : N + 1;
    chk({name, " latency"}, 64'(k), 64'(lat));
    chk({name, " busy cycles"}, 64'(bcnt), 64'(lat));
    chk({name, " hold"}, 64'(hold_ok), 64'd1);
    chk({name, " hi"}, 64'(hi_o), 64'(exp_hi));
    chk({name, " lo"}, 64'(lo_o), 64'(exp_lo));
    chk({name, " divz"}, 64'(divz_o), 64'(exp_dz));
    chk({name, " busy after done"}, 64'(busy_o), 64'd0);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb, rwd, eh, el;
    logic        rwh, rwl, edz;
    bit          stray;

    vecs[0]  = '{2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'd3, 32'd7,         32'd2,         32'd1,         32'd3};
    vecs[4]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[6]  = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[7]  = '{2'd3, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
    vecs[8]  = '{2'd1, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};
    vecs[9]  = '{2'd0, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    vecs[10] = '{2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3};
    vecs[11] = '{2'd3, 32'd5,         32'd9,         32'd5,         32'd0};

    rst_n_i = 1'b0; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    wr_hi_i = 1'b0; wr_lo_i = 1'b0; wdata_i = '0;
    tick();
    tick();
    rst_n_i = 1'b1;
    chk("reset hi", 64'(hi_o), 64'd0);
    chk("reset lo", 64'(lo_o), 64'd0);
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset done", 64'(done_o), 64'd0);
    chk("reset divz", 64'(divz_o), 64'd0);

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, 32'd0, 1'b0,
             vecs[i].hi, vecs[i].lo, 1'b0, $sformatf("vec%0d", i));

    tick();
    chk("done pulse width", 64'(done_o), 64'd0);
    chk("divz idle", 64'(divz_o), 64'd0);
    chk("idle hi hold", 64'(hi_o), 64'(m_hi));

    wr_hi_i = 1'b1; wdata_i = 32'h1234;
    tick();
    wr_hi_i = 1'b0;
    chk("mthi", 64'(hi_o), 64'h1234);
    wr_lo_i = 1'b1; wdata_i = 32'h5678;
    tick();
    wr_lo_i = 1'b0;
    chk("mtlo", 64'(lo_o), 64'h5678);
    chk("mtlo keeps hi", 64'(hi_o), 64'h1234);
    run_op(2'd2, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h1234, 32'h5678, 1'b1, "div5/0");
    tick();
    chk("divz pulse width", 64'(divz_o), 64'd0);
    chk("divz done width", 64'(done_o), 64'd0);

    run_op(2'd1, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 32'd15, 1'b0, "disturbed multu");
    run_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0, 32'd2, 32'd14, 1'b0, "start in done cycle");
    run_op(2'd3, 32'd9, 32'd4, 1'b1, 1'b1, 32'hFFFF, 1'b0, 32'd1, 32'd2, 1'b0, "start+write fix wins");
    run_op(2'd3, 32'd9, 32'd0, 1'b1, 1'b0, 32'hAAAA, 1'b0, 32'hAAAA, 32'd2, 1'b1, "start+write divz");

    start_i = 1'b1; op_i = 2'd0; a_i = 32'hFFFF_FFFD; b_i = 32'd7;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    chk("midrun reset hi", 64'(hi_o), 64'd0);
    chk("midrun reset lo", 64'(lo_o), 64'd0);
    chk("midrun reset busy", 64'(busy_o), 64'd0);
    chk("midrun reset done", 64'(done_o), 64'd0);
    m_hi = '0; m_lo = '0;
    stray = 1'b0;
    for (int c = 0; c < N + 4; c++) begin
      if (done_o || busy_o || hi_o != 32'd0) stray = 1'b1;
      tick();
    end
    chk("discarded op stays silent", 64'(stray), 64'd0);
    run_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0, 32'd2, 32'd14, 1'b0, "divu after reset");

    for (int it = 0; it < 30; it++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      rwh = ($urandom_range(0, 3) == 0);
      rwl = ($urandom_range(0, 3) == 0);
      rwd = $urandom;
      eh = m_hi;
      el = m_lo;
      ref_op(rop, ra, rb, rwh, rwl, rwd, eh, el, edz);
      run_op(rop, ra, rb, rwh, rwl, rwd, 1'(it % 5 == 0 && !edz), eh, el, edz,
             $sformatf("rand%0d op%0d %h/%h", it, rop, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
